// File: rtl/vram_scheduler.sv
// vram_scheduler: arbitrates the single-port video RAM between the clear
// engine, the painter (writes) and the flasher (reads), and sequences the
// frame ring IDLE -> CLEAR -> PAINT -> FLASH.
module vram_scheduler #(
  parameter int                 ADDR_W           = 11,
  parameter int                 COLOR_W          = 3,
  parameter int                 DEPTH            = 1122,
  parameter logic [COLOR_W-1:0] BG_COLOR         = 3'b000,
  parameter logic               CLEAR_EACH_FRAME = 1'b1
) (
  input  logic               Clck,
  input  logic               Reset,
  input  logic               working,
  output logic               paint_start,
  input  logic               paint_done,
  output logic               flash_start,
  input  logic               flash_done,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_color,
  output logic               wr_ack,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_ack,
  output logic               rd_valid,
  output logic [COLOR_W-1:0] rd_data,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_data,
  output logic               ram_wren,
  input  logic [COLOR_W-1:0] ram_q,
  output logic [1:0]         phase,
  output logic [15:0]        frame_cnt,
  output logic               addr_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_PAINT = 2'd2;
  localparam logic [1:0] S_FLASH = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic               working_prev_r;
  logic               work_edge_s;
  logic [ADDR_W-1:0]  clr_cnt_r;
  logic               paint_start_r;
  logic               flash_start_r;
  logic [15:0]        frame_cnt_r;
  logic               addr_err_r;
  logic               rd_valid_r;
  logic [COLOR_W-1:0] rd_last_r;
  logic               wr_in_range_s;
  logic [ADDR_W-1:0]  ram_addr_s;
  logic [COLOR_W-1:0] ram_data_s;
  logic               ram_wren_s;
  logic               wr_ack_s;
  logic               rd_ack_s;

  assign work_edge_s   = working & ~working_prev_r;
  assign wr_in_range_s = (wr_addr <= LAST_ADDR);

  // Next-state decision for the frame ring.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (work_edge_s) state_nxt_s = S_CLEAR;
        else             state_nxt_s = S_IDLE;
      end
      S_CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) state_nxt_s = S_PAINT;
        else                        state_nxt_s = S_CLEAR;
      end
      S_PAINT: begin
        if (paint_done) state_nxt_s = S_FLASH;
        else            state_nxt_s = S_PAINT;
      end
      S_FLASH: begin
        if (!flash_done)           state_nxt_s = S_FLASH;
        else if (!working)         state_nxt_s = S_IDLE;
        else if (CLEAR_EACH_FRAME) state_nxt_s = S_CLEAR;
        else                       state_nxt_s = S_PAINT;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // RAM bus ownership and same-cycle acks; Reset forces the bus idle at once.
  always_comb begin
    ram_addr_s = '0;
    ram_data_s = '0;
    ram_wren_s = 1'b0;
    wr_ack_s   = 1'b0;
    rd_ack_s   = 1'b0;
    if (Reset) begin
      ram_wren_s = 1'b0;
    end else begin
      case (state_r)
        S_CLEAR: begin
          ram_addr_s = clr_cnt_r;
          ram_data_s = BG_COLOR;
          ram_wren_s = 1'b1;
        end
        S_PAINT: begin
          ram_addr_s = wr_addr;
          ram_data_s = wr_color;
          wr_ack_s   = wr_req;
          ram_wren_s = wr_req & wr_in_range_s;
        end
        S_FLASH: begin
          ram_addr_s = rd_addr;
          rd_ack_s   = rd_req;
        end
        default: ram_wren_s = 1'b0;
      endcase
    end
  end

  // State, clear counter, start pulses, frame counter, sticky error, read pipe.
  always_ff @(posedge Clck) begin
    if (Reset) begin
      state_r        <= S_IDLE;
      working_prev_r <= 1'b0;
      clr_cnt_r      <= '0;
      paint_start_r  <= 1'b0;
      flash_start_r  <= 1'b0;
      frame_cnt_r    <= 16'd0;
      addr_err_r     <= 1'b0;
      rd_valid_r     <= 1'b0;
      rd_last_r      <= '0;
    end else begin
      state_r        <= state_nxt_s;
      working_prev_r <= working;
      if ((state_r == S_CLEAR) && (state_nxt_s == S_CLEAR)) clr_cnt_r <= clr_cnt_r + 1'b1;
      else                                                  clr_cnt_r <= '0;
      paint_start_r  <= (state_nxt_s == S_PAINT) && (state_r != S_PAINT);
      flash_start_r  <= (state_nxt_s == S_FLASH) && (state_r != S_FLASH);
      if ((state_r == S_FLASH) && flash_done) frame_cnt_r <= frame_cnt_r + 16'd1;
      else                                    frame_cnt_r <= frame_cnt_r;
      if ((state_r == S_PAINT) && wr_req && !wr_in_range_s) addr_err_r <= 1'b1;
      else                                                  addr_err_r <= addr_err_r;
      rd_valid_r     <= rd_ack_s;
      if (rd_valid_r) rd_last_r <= ram_q;
      else            rd_last_r <= rd_last_r;
    end
  end

  assign ram_addr    = ram_addr_s;
  assign ram_data    = ram_data_s;
  assign ram_wren    = ram_wren_s;
  assign wr_ack      = wr_ack_s;
  assign rd_ack      = rd_ack_s;
  assign rd_valid    = rd_valid_r & ~Reset;
  assign rd_data     = Reset ? '0 : (rd_valid_r ? ram_q : rd_last_r);
  assign phase       = state_r;
  assign paint_start = paint_start_r;
  assign flash_start = flash_start_r;
  assign frame_cnt   = frame_cnt_r;
  assign addr_err    = addr_err_r;

endmodule
